// File: rtl/ucsbece154_icache_rr.sv
// ucsbece154_icache_rr
// Set-associative instruction cache between the fetch stage and the SDRAM
// controller. Hits return one cycle after lookup. Misses refill a whole block
// as an in-order burst. Victims are chosen per set: the lowest invalid way
// first, otherwise round-robin.
//
// Optional feature macro: ICACHE_EARLY_RESTART_EN
//   When defined, the requested word is returned the cycle after its beat
//   arrives, and the rest of the burst completes in the background.
//
// Ports:
//   Clk, Reset          clock, synchronous active-high reset
//   ReadEnable          fetch request, sampled only when Busy=0
//   ReadAddress[31:0]   byte address of the fetch (bits [1:0] ignored)
//   Invalidate          one-cycle pulse, clears every valid bit
//   Instruction         fetched word, valid while Ready=1
//   Ready               one-cycle pulse per completed fetch
//   Busy                refill in progress
//   MemReadAddress      block-aligned refill address
//   MemReadRequest      held high for the whole refill burst
//   MemDataIn           refill beat data
//   MemDataReady        one refill beat valid this cycle
//
// state  | meaning
// IDLE   | lookups accepted; a hit returns its word the next cycle
// REFILL | burst in progress; beats are collected into the line buffer
module ucsbece154_icache_rr #(
  parameter int NUM_SETS    = 8,
  parameter int NUM_WAYS    = 4,
  parameter int BLOCK_WORDS = 4,
  parameter int WORD_SIZE   = 32
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 ReadEnable,
  input  logic [31:0]          ReadAddress,
  input  logic                 Invalidate,
  output logic [WORD_SIZE-1:0] Instruction,
  output logic                 Ready,
  output logic                 Busy,
  output logic [31:0]          MemReadAddress,
  output logic                 MemReadRequest,
  input  logic [31:0]          MemDataIn,
  input  logic                 MemDataReady
);

  localparam int OFF_W   = $clog2(BLOCK_WORDS);
  localparam int IDX_W   = $clog2(NUM_SETS);
  localparam int WAY_W   = $clog2(NUM_WAYS);
  localparam int TAG_LSB = 2 + OFF_W + IDX_W;
  localparam int TAG_W   = 32 - TAG_LSB;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(BLOCK_WORDS - 1);

  typedef enum logic {IDLE, REFILL} state_t;

  state_t state, state_next;

  logic [BLOCK_WORDS-1:0][WORD_SIZE-1:0] data_mem [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]                      tag_mem  [NUM_SETS][NUM_WAYS];
  logic [NUM_SETS-1:0][NUM_WAYS-1:0]     valid;
  logic [NUM_SETS-1:0][WAY_W-1:0]        rr_ptr;

  logic [BLOCK_WORDS-1:0][WORD_SIZE-1:0] line_buf;
  logic [BLOCK_WORDS-1:0][WORD_SIZE-1:0] fill_block;
  logic [31:0]      mem_addr;
  logic [OFF_W-1:0] req_off;
  logic [OFF_W-1:0] beat_cnt;
  logic             inv_pending;

  logic [OFF_W-1:0] lk_off;
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] victim;
  logic             set_full;
  logic             lookup_hit;
  logic             lookup_miss;
  logic             beat_fire;
  logic             last_beat;
  logic             clear_all;

  logic unused_addr_bits;
  assign unused_addr_bits = ^ReadAddress[1:0];

  assign lk_off  = ReadAddress[2 +: OFF_W];
  assign lk_idx  = ReadAddress[2 + OFF_W +: IDX_W];
  assign lk_tag  = ReadAddress[31:TAG_LSB];
  // The refill target is recovered from the registered block address.
  assign req_idx = mem_addr[2 + OFF_W +: IDX_W];
  assign req_tag = mem_addr[31:TAG_LSB];

  assign Busy           = (state == REFILL);
  assign MemReadRequest = (state == REFILL);
  assign MemReadAddress = mem_addr;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid[lk_idx][w] && (tag_mem[lk_idx][w] == lk_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Scanning downward leaves the lowest-index invalid way selected.
  always_comb begin
    victim   = rr_ptr[req_idx];
    set_full = 1'b1;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid[req_idx][w]) begin
        victim   = WAY_W'(w);
        set_full = 1'b0;
      end
    end
  end

  // A lookup that coincides with Invalidate is forced to miss.
  assign lookup_hit  = (state == IDLE) && ReadEnable && hit && !Invalidate;
  assign lookup_miss = (state == IDLE) && ReadEnable && !lookup_hit;
  assign beat_fire   = (state == REFILL) && MemDataReady;
  assign last_beat   = beat_fire && (beat_cnt == LAST_BEAT);
  // An invalidate seen during a refill waits for the fill, so the new line is cleared too.
  assign clear_all   = ((state == IDLE) && Invalidate) ||
                       (last_beat && (inv_pending || Invalidate));

  always_comb begin
    fill_block                = line_buf;
    fill_block[BLOCK_WORDS-1] = MemDataIn;
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (lookup_miss) state_next = REFILL;
      REFILL:  if (last_beat)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (beat_fire) line_buf[beat_cnt] <= MemDataIn;
  end

  always_ff @(posedge Clk) begin
    if (!Reset && last_beat) begin
      data_mem[req_idx][victim] <= fill_block;
      tag_mem[req_idx][victim]  <= req_tag;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Ready       <= 1'b0;
      Instruction <= '0;
      mem_addr    <= '0;
      req_off     <= '0;
      beat_cnt    <= '0;
      inv_pending <= 1'b0;
      valid       <= '0;
      rr_ptr      <= '0;
    end else begin
      Ready <= 1'b0;

      if (lookup_hit) begin
        Ready       <= 1'b1;
        Instruction <= data_mem[lk_idx][hit_way][lk_off];
      end

      if (lookup_miss) begin
        mem_addr <= {ReadAddress[31:2 + OFF_W], {(OFF_W + 2){1'b0}}};
        req_off  <= lk_off;
        beat_cnt <= '0;
      end

      if (beat_fire) begin
        beat_cnt <= beat_cnt + OFF_W'(1);
`ifdef ICACHE_EARLY_RESTART_EN
        if (beat_cnt == req_off) begin
          Ready       <= 1'b1;
          Instruction <= MemDataIn;
        end
`else
        if (last_beat) begin
          Ready       <= 1'b1;
          Instruction <= fill_block[req_off];
        end
`endif
      end

      if ((state == REFILL) && Invalidate) inv_pending <= 1'b1;

      if (last_beat) begin
        valid[req_idx][victim] <= 1'b1;
        // The pointer only moves when an occupied way is evicted.
        if (set_full) rr_ptr[req_idx] <= rr_ptr[req_idx] + WAY_W'(1);
      end

      if (clear_all) begin
        valid       <= '0;
        rr_ptr      <= '0;
        inv_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ucsbece154_icache_rr.sv
// Testbench for ucsbece154_icache_rr (NUM_SETS=8, NUM_WAYS=4, BLOCK_WORDS=4).
// The memory side returns data equal to the beat byte address, so every
// fetched word is expected to equal its own word-aligned address.
module tb_ucsbece154_icache_rr;

`ifdef ICACHE_EARLY_RESTART_EN
  localparam bit ER = 1'b1;
`else
  localparam bit ER = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset;
  logic        ReadEnable;
  logic [31:0] ReadAddress;
  logic        Invalidate;
  logic [31:0] Instruction;
  logic        Ready;
  logic        Busy;
  logic [31:0] MemReadAddress;
  logic        MemReadRequest;
  logic [31:0] MemDataIn;
  logic        MemDataReady;

  int errors = 0;
  int checks = 0;
  logic [31:0] sb[$];

  typedef struct {
    bit          rst;
    logic [31:0] addr;
    bit          hit;
  } vec_t;
  vec_t vecs[$];

  ucsbece154_icache_rr #(
    .NUM_SETS(8), .NUM_WAYS(4), .BLOCK_WORDS(4), .WORD_SIZE(32)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .ReadEnable(ReadEnable),
    .ReadAddress(ReadAddress),
    .Invalidate(Invalidate),
    .Instruction(Instruction),
    .Ready(Ready),
    .Busy(Busy),
    .MemReadAddress(MemReadAddress),
    .MemReadRequest(MemReadRequest),
    .MemDataIn(MemDataIn),
    .MemDataReady(MemDataReady)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Every Ready pulse must match the oldest outstanding expected word.
  always @(negedge Clk) begin
    if (Ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got Instruction 0x%08h expected no Ready at %0t", Instruction, $time);
      end else begin
        check("instruction", Instruction, sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    Reset = 1'b1; ReadEnable = 1'b0; Invalidate = 1'b0; MemDataReady = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b0;
    check("rst_ready", Ready, 0);
    check("rst_busy", Busy, 0);
    check("rst_req", MemReadRequest, 0);
    check("rst_instr", Instruction, 0);
    check("rst_maddr", MemReadAddress, 0);
  endtask

  // Called right after MemReadRequest rises; delivers the four beats in order.
  task automatic serve(input logic [31:0] a, input bit gap, input bit inv_mid);
    logic [31:0] base;
    int off;
    base = {a[31:4], 4'b0000};
    off  = int'(a[3:2]);
    for (int b = 0; b < 4; b++) begin
      if (gap && b == 2) begin
        MemDataReady = 1'b0;
        @(posedge Clk); #1;
        check("gap_ready", Ready, 0);
        check("gap_req", MemReadRequest, 1);
      end
      MemDataReady = 1'b1;
      MemDataIn    = base + 32'(4 * b);
      Invalidate   = inv_mid && (b == 1);
      @(posedge Clk); #1;
      MemDataReady = 1'b0;
      Invalidate   = 1'b0;
      check("beat_ready", Ready, (ER ? (b == off) : (b == 3)) ? 1 : 0);
      check("beat_busy", Busy, (b != 3) ? 1 : 0);
      check("beat_req", MemReadRequest, (b != 3) ? 1 : 0);
      check("beat_maddr", MemReadAddress, base);
    end
  endtask

  task automatic lookup(input logic [31:0] a, input bit exp_hit, input bit inv,
                        input bit gap, input bit inv_mid);
    ReadAddress = a; ReadEnable = 1'b1; Invalidate = inv;
    sb.push_back({a[31:2], 2'b00});
    @(posedge Clk); #1;
    ReadEnable = 1'b0; Invalidate = 1'b0;
    if (exp_hit) begin
      check("hit_ready", Ready, 1);
      check("hit_busy", Busy, 0);
    end else begin
      check("miss_ready", Ready, 0);
      check("miss_req", MemReadRequest, 1);
      check("miss_busy", Busy, 1);
      check("miss_maddr", MemReadAddress, {a[31:4], 4'b0000});
      serve(a, gap, inv_mid);
    end
  endtask

  initial begin
    logic [31:0] b2b[3];

    vecs.push_back('{1'b1, 32'h0000_1004, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_1008, 1'b1});
    vecs.push_back('{1'b0, 32'h0000_1000, 1'b1});
    vecs.push_back('{1'b0, 32'h0000_100C, 1'b1});
    vecs.push_back('{1'b0, 32'h0000_1010, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_1014, 1'b1});
    vecs.push_back('{1'b1, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0080, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0100, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0180, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0084, 1'b1});
    vecs.push_back('{1'b0, 32'h0000_0200, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0280, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0108, 1'b1});
    vecs.push_back('{1'b0, 32'h0000_018C, 1'b1});
    vecs.push_back('{1'b0, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0100, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0180, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0284, 1'b1});
    vecs.push_back('{1'b0, 32'h0000_0004, 1'b1});
    vecs.push_back('{1'b0, 32'h0000_010C, 1'b1});
    vecs.push_back('{1'b0, 32'h0000_0204, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0280, 1'b0});

    Reset = 1'b1; ReadEnable = 1'b0; ReadAddress = '0; Invalidate = 1'b0;
    MemDataIn = '0; MemDataReady = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      lookup(vecs[i].addr, vecs[i].hit, 1'b0, (i % 3) == 0, 1'b0);
    end

    // Invalidate pulse in IDLE, then a lookup coinciding with Invalidate.
    do_reset();
    lookup(32'h0000_1000, 1'b0, 1'b0, 1'b0, 1'b0);
    Invalidate = 1'b1;
    @(posedge Clk); #1;
    Invalidate = 1'b0;
    check("inv_idle_ready", Ready, 0);
    lookup(32'h0000_1004, 1'b0, 1'b0, 1'b0, 1'b0);
    lookup(32'h0000_1008, 1'b1, 1'b0, 1'b0, 1'b0);
    lookup(32'h0000_100C, 1'b0, 1'b1, 1'b0, 1'b0);

    // Invalidate during a refill: word still delivered, both lines gone after.
    do_reset();
    lookup(32'h0000_1000, 1'b0, 1'b0, 1'b0, 1'b0);
    lookup(32'h0000_2000, 1'b0, 1'b0, 1'b1, 1'b1);
    lookup(32'h0000_2000, 1'b0, 1'b0, 1'b0, 1'b0);
    lookup(32'h0000_1000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset after beat 1 abandons the burst; later beats are ignored.
    do_reset();
    ReadAddress = 32'h0000_400C; ReadEnable = 1'b1;
    @(posedge Clk); #1;
    ReadEnable = 1'b0;
    check("abort_req_up", MemReadRequest, 1);
    for (int b = 0; b < 2; b++) begin
      MemDataReady = 1'b1; MemDataIn = 32'h0000_4000 + 32'(4 * b);
      @(posedge Clk); #1;
    end
    MemDataIn = 32'h0000_4008; Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    check("abort_req", MemReadRequest, 0);
    check("abort_busy", Busy, 0);
    check("abort_ready", Ready, 0);
    check("abort_maddr", MemReadAddress, 0);
    check("abort_instr", Instruction, 0);
    MemDataIn = 32'h0000_400C;
    @(posedge Clk); #1;
    MemDataReady = 1'b0;
    check("late_beat_ready", Ready, 0);
    check("late_beat_busy", Busy, 0);
    check("late_beat_req", MemReadRequest, 0);
    lookup(32'h0000_400C, 1'b0, 1'b0, 1'b0, 1'b0);

    // Early-restart case (Ready position depends on the build), then back-to-back hits.
    do_reset();
    lookup(32'h0000_3004, 1'b0, 1'b0, 1'b1, 1'b0);
    b2b[0] = 32'h0000_3000; b2b[1] = 32'h0000_3008; b2b[2] = 32'h0000_300C;
    for (int k = 0; k < 3; k++) begin
      ReadAddress = b2b[k]; ReadEnable = 1'b1;
      sb.push_back(b2b[k]);
      @(posedge Clk); #1;
      check("b2b_ready", Ready, 1);
      check("b2b_busy", Busy, 0);
    end
    ReadEnable = 1'b0;
    @(posedge Clk); #1;
    check("b2b_end_ready", Ready, 0);

    @(posedge Clk); #1;
    check("sb_drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ucsbece154_icache_rr.md
# ucsbece154_icache_rr

Parametrised set-associative instruction cache between the core fetch stage and the SDRAM controller. It is the successor to the fixed-geometry icache. It adds:
- any power-of-two geometry;
- deterministic per-set round-robin replacement;
- a whole-cache invalidate;
- optional early restart on refill.

Hits return one cycle after lookup. Misses run a burst refill of one block from SDRAM.

## Interface
- NUM_SETS, 8: sets; power of two, ≥2.
- NUM_WAYS, 4: ways per set; power of two, ≥2.
- BLOCK_WORDS, 4: 32-bit words per block; power of two, ≥2.
- WORD_SIZE, 32: instruction width; fixed at 32.

Ports (clock and reset first):
- Clk  in  1  single clock; all state on rising edge.
- Reset  in  1  synchronous, active-high reset.
- ReadEnable  in  1  fetch request; sampled only when Busy=0.
- ReadAddress  in  32  byte address; bits [1:0] ignored.
- Invalidate  in  1  one-cycle pulse; clears all valid bits.
- Instruction  out  WORD_SIZE  fetched word; valid when Ready=1.
- Ready  out  1  one-cycle pulse per completed fetch.
- Busy  out  1  refill in progress; core must hold fetch.
- MemReadAddress  out  32  block-aligned refill address.
- MemReadRequest  out  1  held high for the whole refill burst.
- MemDataIn  in  32  refill beat data.
- MemDataReady  in  1  one beat valid this cycle.

## Operation

Address split, LSB first:
- 2 byte bits;
- log2(BLOCK_WORDS) word-offset bits;
- log2(NUM_SETS) index bits;
- remaining bits are the tag.

State machine has two states, IDLE and REFILL.
- IDLE, ReadEnable=1, hit (valid and tag match in any way):
  - next cycle Instruction = the word at that way and offset, Ready=1;
  - stay IDLE.
- IDLE, ReadEnable=1, miss:
  - latch ReadAddress;
  - next cycle go to REFILL with MemReadRequest=1, Busy=1, and MemReadAddress = {ReadAddress[31:log2(BLOCK_WORDS)+2], zeros}.
- REFILL:
  - each cycle with MemDataReady=1 writes MemDataIn into line-buffer slot beat_cnt, then beat_cnt increments;
  - beats arrive in order, word 0 first.
- Last beat (beat_cnt = BLOCK_WORDS-1):
  - write the line buffer plus that beat into the victim way, set the tag, set valid;
  - next cycle: Instruction = requested word, Ready=1, Busy=0, MemReadRequest=0, state IDLE.
- Victim selection:
  - the lowest-index invalid way in the set;
  - if none is invalid, the set's rr_ptr, which then increments modulo NUM_WAYS;
  - rr_ptr changes only on a fill into a full set.
- Invalidate in IDLE:
  - all valid bits and rr_ptrs clear at the next edge;
  - a simultaneous lookup is treated as a miss.
- Invalidate in REFILL:
  - latched as pending;
  - the refill completes and its Ready/Instruction are delivered;
  - the clear is applied on the cycle Busy falls, so the just-filled line is also invalid.
- ReadEnable while Busy=1 is ignored; the core re-presents the address.
- Reset at any time:
  - Ready, Busy, MemReadRequest = 0; Instruction, MemReadAddress = 0;
  - all valid bits, rr_ptrs, beat_cnt and pending-invalidate cleared;
  - an in-flight burst is abandoned, and beats arriving after reset are ignored.

## Timing
- Hit latency: 1 cycle (request edge N → Ready at N+1).
- Miss latency: 1 cycle to raise MemReadRequest, plus the SDRAM beats, plus 1 cycle after the last beat.
- Ready is never high for two consecutive cycles from one request.
- Ready is never high at the same time as MemReadRequest, except under early restart (see Configuration).
- MemReadAddress is stable while MemReadRequest=1.
- MemDataReady while not in REFILL is ignored.
- Back-to-back hits: Ready is high every cycle, each pulse for the previous cycle's address.

## Configuration
- ICACHE_EARLY_RESTART_EN defined:
  - the cycle after the beat whose index equals the requested word offset, Ready=1 with that beat as Instruction;
  - Busy and MemReadRequest stay high until the last beat;
  - no second Ready at the end of the fill.
- ICACHE_EARLY_RESTART_EN not defined:
  - Ready only after the last beat, as described in Operation.

## Test plan
Configuration for all scenarios: NUM_SETS=8, NUM_WAYS=4, BLOCK_WORDS=4. The memory model returns data = beat address.
- Cold miss, read 0x0000_1004:
  - MemReadAddress=0x0000_1000 held with MemReadRequest for 4 beats;
  - Ready with Instruction=0x0000_1004 one cycle after beat 3;
  - re-reading 0x0000_1008 hits with 1-cycle latency.
- Fill set 0 with tags for 0x000, 0x080, 0x100, 0x180, then read 0x200 and 0x280:
  - 0x200 replaces way 0, 0x280 replaces way 1;
  - a subsequent read of 0x000 misses, a read of 0x100 hits.
- Invalidate pulse after filling 0x1000, then read 0x1004 → refill occurs.
- Invalidate during a refill of 0x2000:
  - Ready delivers 0x2000;
  - the next read of 0x2000 misses.
- Reset asserted after beat 1 of a refill:
  - MemReadRequest=0 and Busy=0 next cycle;
  - later beats are ignored;
  - a read of the same address misses.
- Early restart, read 0x0000_3004:
  - with ICACHE_EARLY_RESTART_EN, Ready comes one cycle after beat 1 with Busy still 1;
  - without the macro, Ready comes one cycle after beat 3.
